// File: rtl/fixed_point_pkg.sv
// Shared types and derived-constant helpers for the iterative fixed-point divider.
package fixed_point_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_e;

  function automatic int shift_bits(input int a_frac, input int b_frac, input int p_frac);
    return p_frac + b_frac - a_frac;
  endfunction

  function automatic int iter_count(input int a_width, input int shift);
    return a_width + shift;
  endfunction

endpackage

// File: rtl/fixed_point_sign_mag.sv
// Combinational two's-complement to sign/magnitude; magnitude is one bit wider so -2^(W-1) is exact.
module fixed_point_sign_mag
  import fixed_point_pkg::*;
#(
  parameter int W = 25
) (
  input  logic [W-1:0] val,
  output logic [W:0]   mag,
  output logic         neg
);

  logic [W:0] ext_s;

  assign neg   = val[W-1];
  assign ext_s = {val[W-1], val};
  assign mag   = neg ? (~ext_s + {{W{1'b0}}, 1'b1}) : ext_s;

endmodule

// File: rtl/fixed_point_slow_div.sv
// Iterative signed fixed-point divider, one restoring quotient bit per clock.
// Optional saturation and error flag enabled by defining FIXED_DIV_SATURATE_EN.
module fixed_point_slow_div
  import fixed_point_pkg::*;
#(
  parameter int A_WIDTH     = 25,
  parameter int B_WIDTH     = 18,
  parameter int A_FRAC_BITS = 14,
  parameter int B_FRAC_BITS = 14,
  parameter int P_FRAC_BITS = 14,
  parameter int P_WIDTH     = 32
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic               valid_in,
  output logic               ready_out,
  output logic               valid_out,
  output logic [P_WIDTH-1:0] P,
  output logic               err_out
);

  localparam int SHIFT = shift_bits(A_FRAC_BITS, B_FRAC_BITS, P_FRAC_BITS);
  localparam int ITER  = iter_count(A_WIDTH, SHIFT);
  localparam int CW    = $clog2(ITER + 1);
  localparam int RW    = B_WIDTH + 1;
  localparam int EXT_W = ITER + P_WIDTH + 1;

  generate
    if (SHIFT < 0) begin : g_shift_chk
      $error("fixed_point_slow_div: P_FRAC_BITS + B_FRAC_BITS must be >= A_FRAC_BITS");
    end
  endgenerate

  div_state_e         state_r;
  div_state_e         state_nxt_s;
  logic [A_WIDTH:0]   a_mag_s;
  logic               a_neg_s;
  logic [B_WIDTH:0]   b_mag_s;
  logic               b_neg_s;
  logic               accept_s;
  logic               last_s;
  logic [ITER-1:0]    num_r;
  logic [RW-1:0]      dvs_r;
  logic [RW-1:0]      rem_r;
  logic [ITER-2:0]    quo_r;
  logic [CW-1:0]      cnt_r;
  logic               sign_r;
  logic [P_WIDTH-1:0] p_r;
  logic               valid_r;
  logic [RW:0]        rem_shift_s;
  logic               ge_s;
  logic [RW-1:0]      rem_next_s;
  logic [ITER-1:0]    q_fin_s;
  logic [P_WIDTH-1:0] res_s;

  fixed_point_sign_mag #(.W(A_WIDTH)) u_a_sm (.val(A), .mag(a_mag_s), .neg(a_neg_s));
  fixed_point_sign_mag #(.W(B_WIDTH)) u_b_sm (.val(B), .mag(b_mag_s), .neg(b_neg_s));

  assign ready_out = (state_r == IDLE) && !rst_in;
  assign accept_s  = valid_in && ready_out;
  assign last_s    = (state_r == BUSY) && (cnt_r == CW'(1));
  assign valid_out = valid_r;
  assign P         = p_r;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = BUSY;
        else          state_nxt_s = IDLE;
      end
      BUSY: begin
        if (last_s) state_nxt_s = IDLE;
        else        state_nxt_s = BUSY;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // One restoring step: bring in the next numerator bit, subtract when it fits
  always_comb begin
    rem_shift_s = {rem_r, num_r[ITER-1]};
    ge_s        = (rem_shift_s >= {1'b0, dvs_r});
    if (ge_s) rem_next_s = RW'(rem_shift_s - {1'b0, dvs_r});
    else      rem_next_s = RW'(rem_shift_s);
  end

`ifdef FIXED_DIV_SATURATE_EN
  localparam logic [EXT_W-1:0]   POS_MAX = (EXT_W'(1) << (P_WIDTH - 1)) - EXT_W'(1);
  localparam logic [EXT_W-1:0]   NEG_MAG = EXT_W'(1) << (P_WIDTH - 1);
  localparam logic [P_WIDTH-1:0] P_MAX   = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic [P_WIDTH-1:0] P_MIN   = {1'b1, {(P_WIDTH-1){1'b0}}};

  logic zero_div_r;
  logic a_neg_r;
  logic err_r;
  logic err_s;

  assign err_out = err_r;
`else
  assign err_out = 1'b0;
`endif

  // Final quotient: apply sign, then saturate when enabled
  always_comb begin
    q_fin_s = {quo_r, ge_s};
    res_s   = P_WIDTH'(sign_r ? ({EXT_W{1'b0}} - EXT_W'(q_fin_s)) : EXT_W'(q_fin_s));
`ifdef FIXED_DIV_SATURATE_EN
    err_s = 1'b0;
    if (zero_div_r) begin
      err_s = 1'b1;
      res_s = a_neg_r ? P_MIN : P_MAX;
    end else if (sign_r && (EXT_W'(q_fin_s) > NEG_MAG)) begin
      err_s = 1'b1;
      res_s = P_MIN;
    end else if (!sign_r && (EXT_W'(q_fin_s) > POS_MAX)) begin
      err_s = 1'b1;
      res_s = P_MAX;
    end else begin
      err_s = 1'b0;
    end
`endif
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      num_r   <= '0;
      dvs_r   <= '0;
      rem_r   <= '0;
      quo_r   <= '0;
      cnt_r   <= '0;
      sign_r  <= 1'b0;
      p_r     <= '0;
      valid_r <= 1'b0;
`ifdef FIXED_DIV_SATURATE_EN
      zero_div_r <= 1'b0;
      a_neg_r    <= 1'b0;
      err_r      <= 1'b0;
`endif
    end else begin
      valid_r <= 1'b0;
`ifdef FIXED_DIV_SATURATE_EN
      err_r   <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            num_r  <= ITER'(a_mag_s) << SHIFT;
            dvs_r  <= b_mag_s;
            rem_r  <= '0;
            quo_r  <= '0;
            cnt_r  <= CW'(ITER);
            sign_r <= a_neg_s ^ b_neg_s;
`ifdef FIXED_DIV_SATURATE_EN
            zero_div_r <= (B == {B_WIDTH{1'b0}});
            a_neg_r    <= a_neg_s;
`endif
          end
        end
        BUSY: begin
          num_r <= {num_r[ITER-2:0], 1'b0};
          rem_r <= rem_next_s;
          quo_r <= {quo_r[ITER-3:0], ge_s};
          cnt_r <= cnt_r - CW'(1);
          if (last_s) begin
            p_r     <= res_s;
            valid_r <= 1'b1;
`ifdef FIXED_DIV_SATURATE_EN
            err_r   <= err_s;
`endif
          end
        end
        default: begin
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_slow_div.sv
// Self-checking bench for fixed_point_slow_div: directed cases plus randomized operands against an arithmetic model.
module tb_fixed_point_slow_div;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [24:0] A;
  logic [17:0] B;
  logic        valid_in;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] P;
  logic        err_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  fixed_point_slow_div dut (
    .clk_in(clk_in), .rst_in(rst_in), .A(A), .B(B), .valid_in(valid_in),
    .ready_out(ready_out), .valid_out(valid_out), .P(P), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: quotient = trunc(|A| * 2^SHIFT / |B|), sign applied afterwards; returns {err, P}
  function automatic logic [32:0] model_div(input logic signed [24:0] a, input logic signed [17:0] b);
    longint la, lb, ua, ub, q;
    logic neg, err;
    logic [31:0] p;
    la  = a;
    lb  = b;
    ua  = (la < 0) ? -la : la;
    ub  = (lb < 0) ? -lb : lb;
    neg = (la < 0) != (lb < 0);
    if (ub == 0) q = (longint'(1) << 39) - 1;
    else         q = (ua << 14) / ub;
    p   = neg ? 32'(-q) : 32'(q);
    err = 1'b0;
`ifdef FIXED_DIV_SATURATE_EN
    if (lb == 0) begin
      err = 1'b1;
      p   = (la < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (!neg && q > 64'sd2147483647) begin
      err = 1'b1;
      p   = 32'h7FFF_FFFF;
    end else if (neg && q > 64'sd2147483648) begin
      err = 1'b1;
      p   = 32'h8000_0000;
    end
`endif
    return {err, p};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!ready_out && n < 100) begin
      @(posedge clk_in); #1;
      n++;
    end
    check_eq("ready_wait", ready_out, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [24:0] a, input logic [17:0] b,
                        input logic [31:0] exp_p, input logic exp_err);
    int lat;
    wait_ready();
    A = a; B = b; valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    check_eq({tag, "_busy"}, ready_out, 1'b0);
    lat = 0;
    while (!valid_out && lat < 60) begin
      @(posedge clk_in); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, lat, 39);
    check_eq({tag, "_p"}, P, exp_p);
    check_eq({tag, "_err"}, err_out, exp_err);
    check_eq({tag, "_rdy"}, ready_out, 1'b1);
    @(posedge clk_in); #1;
    check_eq({tag, "_pulse"}, valid_out, 1'b0);
    check_eq({tag, "_hold"}, P, exp_p);
  endtask

  initial begin
    logic [32:0] m;
    logic [24:0] ba [4];
    logic [17:0] bb [4];
    int          acc [4];
    int          lat;
    logic        seen;
    logic [24:0] ra;
    logic [17:0] rb;

    rst_in = 1'b1; valid_in = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check_eq("rst_ready", ready_out, 1'b0);
    check_eq("rst_valid", valid_out, 1'b0);
    check_eq("rst_p", P, 32'h0);
    check_eq("rst_err", err_out, 1'b0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    check_eq("post_rst_ready", ready_out, 1'b1);

    run_op("d_3_by_1p5", 25'd49152, 18'd24576, 32'd32768, 1'b0);
    run_op("d_neg_by_4", -25'sd16384, 18'd65536, 32'hFFFF_F000, 1'b0);
    run_op("d_trunc", -25'sd16384, 18'd49152, 32'hFFFF_EAAB, 1'b0);
`ifdef FIXED_DIV_SATURATE_EN
    run_op("d_div0", 25'd16384, 18'd0, 32'h7FFF_FFFF, 1'b1);
    run_op("d_div0_neg", -25'sd16384, 18'd0, 32'h8000_0000, 1'b1);
    run_op("d_ovf", 25'd16777215, 18'd1, 32'h7FFF_FFFF, 1'b1);
`else
    run_op("d_div0", 25'd16384, 18'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("d_div0_neg", -25'sd16384, 18'd0, 32'h0000_0001, 1'b0);
    run_op("d_ovf", 25'd16777215, 18'd1, 32'hFFFF_C000, 1'b0);
`endif
    run_op("d_minmin", 25'h100_0000, 18'h2_0000, 32'h0020_0000, 1'b0);

    // Reset in the middle of an operation
    wait_ready();
    A = 25'd16384; B = 18'd16384; valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    repeat (9) begin
      @(posedge clk_in); #1;
    end
    rst_in = 1'b1;
    #1;
    check_eq("midrst_ready_low", ready_out, 1'b0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    #1;
    check_eq("midrst_ready_back", ready_out, 1'b1);
    check_eq("midrst_p", P, 32'h0);
    seen = 1'b0;
    repeat (50) begin
      @(posedge clk_in); #1;
      if (valid_out) seen = 1'b1;
    end
    check_eq("midrst_no_valid", seen, 1'b0);
    run_op("after_rst", 25'd32768, 18'd16384, 32'd32768, 1'b0);

    // Back-to-back: valid_in held high, operands change after each accept
    for (int i = 0; i < 4; i++) begin
      ba[i] = 25'($urandom);
      bb[i] = 18'($urandom_range(1, 131071));
    end
    A = ba[0]; B = bb[0]; valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      acc[i] = cyc;
      if (i > 0) check_eq("b2b_spacing", acc[i] - acc[i-1], 40);
      @(posedge clk_in); #1;
      if (i < 3) begin
        A = ba[i+1]; B = bb[i+1];
      end else begin
        valid_in = 1'b0;
      end
      lat = 0;
      while (!valid_out && lat < 60) begin
        @(posedge clk_in); #1;
        lat++;
      end
      m = model_div(ba[i], bb[i]);
      check_eq("b2b_lat", lat, 39);
      check_eq("b2b_p", P, m[31:0]);
      check_eq("b2b_err", err_out, m[32]);
      check_eq("b2b_rdy", ready_out, 1'b1);
    end

    // Randomized operands with a mix of divisor magnitudes
    for (int i = 0; i < 20; i++) begin
      ra = 25'($urandom);
      case ($urandom_range(0, 4))
        0:       rb = 18'($urandom_range(1, 64));
        1:       rb = -18'($urandom_range(1, 64));
        2:       rb = 18'($urandom_range(8192, 32768));
        3:       rb = (i == 7) ? 18'd0 : 18'($urandom);
        default: rb = 18'($urandom);
      endcase
      m = model_div(ra, rb);
      run_op("rnd", ra, rb, m[31:0], m[32]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
